// File: rtl/chatter_counter_if.sv
// Button-side bundle for chatter_counter: raw switch in, debounced level/toggle out.
// Optional presspulse is present only when CHATTER_PULSE_EN is defined.
interface chatter_counter_if;
  logic switchin;
  logic ispressed;
  logic enabled;
`ifdef CHATTER_PULSE_EN
  logic presspulse;

  modport master (output switchin, input ispressed, input enabled, input presspulse);
  modport slave  (input switchin, output ispressed, output enabled, output presspulse);
`else
  modport master (output switchin, input ispressed, input enabled);
  modport slave  (input switchin, output ispressed, output enabled);
`endif
endinterface

// File: rtl/chatter_counter.sv
// Push-button debouncer: 2-flop sync + stability counter, level + toggle outputs (+presspulse with CHATTER_PULSE_EN).
// Latency 2+STABLE_COUNT edges counting the first sampling edge; no backpressure, outputs registered.
module chatter_counter #(
  parameter int unsigned STABLE_COUNT = 16,
  parameter int unsigned CNT_WIDTH    = 20,
  parameter bit          ACTIVE_LOW   = 1'b0
) (
  input  logic              chatterclock,
  input  logic              chatterreset_n,
  chatter_counter_if.slave  bus
);

  localparam logic                 IDLE_LVL = ACTIVE_LOW;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);

  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ispressed_q, ispressed_d;
  logic                 enabled_q, enabled_d;
  logic                 raw_pressed;
`ifdef CHATTER_PULSE_EN
  logic                 presspulse_q, presspulse_d;
`endif

  assign raw_pressed = sync2_q ^ ACTIVE_LOW;

  always_comb begin
    sync1_d     = bus.switchin;
    sync2_d     = sync1_q;
    cnt_d       = cnt_q;
    ispressed_d = ispressed_q;
    enabled_d   = enabled_q;
`ifdef CHATTER_PULSE_EN
    presspulse_d = 1'b0;
`endif
    // Any sample matching the debounced level restarts the stability window.
    if (raw_pressed == ispressed_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d       = '0;
      ispressed_d = raw_pressed;
      if (raw_pressed) begin
        enabled_d = ~enabled_q;
`ifdef CHATTER_PULSE_EN
        presspulse_d = 1'b1;
`endif
      end
    end else begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge chatterclock or negedge chatterreset_n) begin
    if (!chatterreset_n) begin
      sync1_q     <= IDLE_LVL;
      sync2_q     <= IDLE_LVL;
      cnt_q       <= '0;
      ispressed_q <= 1'b0;
      enabled_q   <= 1'b0;
`ifdef CHATTER_PULSE_EN
      presspulse_q <= 1'b0;
`endif
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cnt_q       <= cnt_d;
      ispressed_q <= ispressed_d;
      enabled_q   <= enabled_d;
`ifdef CHATTER_PULSE_EN
      presspulse_q <= presspulse_d;
`endif
    end
  end

  assign bus.ispressed = ispressed_q;
  assign bus.enabled   = enabled_q;
`ifdef CHATTER_PULSE_EN
  assign bus.presspulse = presspulse_q;
`endif

endmodule

// File: tb/tb_chatter_counter.sv
// Bench for chatter_counter: active-high and active-low instances driven with the same press pattern.
// Directed table, hand-written reset sequence, then random presses against a run-length reference model.
module tb_chatter_counter;

  localparam int S = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  chatter_counter_if bus_h ();
  chatter_counter_if bus_l ();

  chatter_counter #(.STABLE_COUNT(S), .CNT_WIDTH(20), .ACTIVE_LOW(1'b0)) dut_h (
    .chatterclock  (clk),
    .chatterreset_n(rst_n),
    .bus           (bus_h.slave)
  );

  chatter_counter #(.STABLE_COUNT(S), .CNT_WIDTH(20), .ACTIVE_LOW(1'b1)) dut_l (
    .chatterclock  (clk),
    .chatterreset_n(rst_n),
    .bus           (bus_l.slave)
  );

  typedef struct {
    bit sw;
    bit ip;
    bit en;
    bit pl;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: pressed-sense samples delayed two edges, then a flip once the
  // last S filtered samples all disagree with the debounced level.
  bit m_ip, m_en, m_pulse;
  bit hist[$];
  bit rq[$];

  task automatic chk(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, want %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/ip_h"}, bus_h.ispressed, m_ip);
    chk({tag, "/en_h"}, bus_h.enabled,   m_en);
    chk({tag, "/ip_l"}, bus_l.ispressed, m_ip);
    chk({tag, "/en_l"}, bus_l.enabled,   m_en);
`ifdef CHATTER_PULSE_EN
    chk({tag, "/pl_h"}, bus_h.presspulse, m_pulse);
    chk({tag, "/pl_l"}, bus_l.presspulse, m_pulse);
`endif
  endtask

  task automatic model_reset();
    m_ip = 1'b0;
    m_en = 1'b0;
    m_pulse = 1'b0;
    hist.delete();
    hist.push_back(1'b0);
    hist.push_back(1'b0);
    rq.delete();
  endtask

  task automatic model_edge(input bit pr);
    bit raw;
    bit all_diff;
    raw = hist.pop_front();
    hist.push_back(pr);
    rq.push_back(raw);
    if (rq.size() > S) void'(rq.pop_front());
    m_pulse = 1'b0;
    if (rq.size() == S) begin
      all_diff = 1'b1;
      foreach (rq[i]) if (rq[i] == m_ip) all_diff = 1'b0;
      if (all_diff) begin
        m_ip = ~m_ip;
        if (m_ip) begin
          m_en = ~m_en;
          m_pulse = 1'b1;
        end
      end
    end
  endtask

  task automatic drive(input bit pr);
    bus_h.switchin = pr;
    bus_l.switchin = ~pr;
  endtask

  task automatic step(input bit pr);
    drive(pr);
    @(posedge clk);
    model_edge(pr);
    #1;
  endtask

  task automatic add(input bit sw, input bit ip, input bit en, input bit pl, input int n);
    vec_t v;
    v.sw = sw; v.ip = ip; v.en = en; v.pl = pl;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // Asynchronous reset pulse placed between clock edges; outputs must clear at once.
  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all(tag);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    bit pr;
    drive(1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Clean press, hold, release, second press, release, bounce, steady press.
    add(1, 0, 0, 0, 5);  add(1, 1, 1, 1, 1);  add(1, 1, 1, 0, 20);
    add(0, 1, 1, 0, 5);  add(0, 0, 1, 0, 1);
    add(1, 0, 1, 0, 5);  add(1, 1, 0, 1, 1);  add(1, 1, 0, 0, 2);
    add(0, 1, 0, 0, 5);  add(0, 0, 0, 0, 3);
    add(1, 0, 0, 0, 1);  add(0, 0, 0, 0, 1);  add(1, 0, 0, 0, 2);
    add(0, 0, 0, 0, 1);  add(1, 0, 0, 0, 3);  add(0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 5);  add(1, 1, 1, 1, 1);  add(1, 1, 1, 0, 3);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].sw);
      chk($sformatf("tbl%0d/ip_h", i), bus_h.ispressed, vecs[i].ip);
      chk($sformatf("tbl%0d/en_h", i), bus_h.enabled,   vecs[i].en);
      chk($sformatf("tbl%0d/ip_l", i), bus_l.ispressed, vecs[i].ip);
      chk($sformatf("tbl%0d/en_l", i), bus_l.enabled,   vecs[i].en);
`ifdef CHATTER_PULSE_EN
      chk($sformatf("tbl%0d/pl_h", i), bus_h.presspulse, vecs[i].pl);
      chk($sformatf("tbl%0d/pl_l", i), bus_l.presspulse, vecs[i].pl);
`endif
      check_all($sformatf("tbl%0d/model", i));
    end

    // Button held (enabled=1) through reset: re-acquired as a fresh press.
    reset_pulse("midreset");
    chk("midreset/ip_h", bus_h.ispressed, 1'b0);
    chk("midreset/en_h", bus_h.enabled,   1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1);
      chk($sformatf("reacq%0d/ip_h", i), bus_h.ispressed, 1'b0);
      chk($sformatf("reacq%0d/ip_l", i), bus_l.ispressed, 1'b0);
    end
    step(1'b1);
    chk("reacq5/ip_h", bus_h.ispressed, 1'b1);
    chk("reacq5/en_h", bus_h.enabled,   1'b1);
    chk("reacq5/ip_l", bus_l.ispressed, 1'b1);
    chk("reacq5/en_l", bus_l.enabled,   1'b1);
    check_all("reacq5/model");

    // Random presses with bounce and occasional asynchronous resets.
    pr = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(5) == 0) pr = ~pr;
      step(pr);
      check_all($sformatf("rnd%0d", c));
      if ($urandom_range(399) == 0) reset_pulse($sformatf("rndrst%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
